// File: rtl/edge_evt_pkg.sv
// Shared definitions for the edge event scheduler: edge-mode codes, FSM state, round-robin pick.
// Latency: n/a (package only).
// Backpressure: n/a.
package edge_evt_pkg;

    localparam int EDGE_ANY  = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } fsm_state_t;

    // First set bit of pend searching from last+1, wrapping modulo n (n <= 16).
    // Returns last unchanged when nothing is pending; callers gate on |pend.
    function automatic int rr_pick(input logic [15:0] pend, input int last, input int n);
        int  res;
        int  idx;
        bit  found;
        res   = last;
        found = 1'b0;
        for (int off = 1; off <= 16; off++) begin
            if (off <= n && !found) begin
                idx = (last + off) % n;
                if (pend[idx[3:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_event_scheduler_if.sv
// Event offer handshake between the scheduler (master) and its consumer (slave).
// Latency: n/a (wires only).
// Backpressure: evt_ready from the consumer stalls the offer; channel/level hold while stalled.
interface edge_event_scheduler_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_channel;
    logic            evt_level;

    modport master (output evt_valid, output evt_channel, output evt_level, input evt_ready);
    modport slave  (input evt_valid, input evt_channel, input evt_level, output evt_ready);

endinterface

// File: rtl/edge_sync_detect.sv
// One channel: synchronizer chain, previous-level register and edge-mode qualification.
// Latency: edge_det asserts SYNC_STAGES cycles after the input changes, for one cycle.
// Backpressure: none; edges are reported whenever they occur (arm gates them after reset).
// Ports: clk/reset, signal_in (async line), arm (edge enable), edge_det (qualified edge), level (synced level).
module edge_sync_detect
    import edge_evt_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_ANY
) (
    input  logic clk,
    input  logic reset,
    input  logic signal_in,
    input  logic arm,
    output logic edge_det,
    output logic level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

    always_comb begin
        edge_det = 1'b0;
        if (arm && (level != prev_q)) begin
            case (EDGE_MODE)
                EDGE_RISE: edge_det = level;
                EDGE_FALL: edge_det = !level;
                default:   edge_det = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// Collects per-channel edge events into pending bits and serializes them round-robin onto one port.
// Latency: input change to evt_valid is SYNC_STAGES+1 cycles when idle; one event per cycle thereafter.
// Backpressure: evt_ready low holds the offer; further edges on a still-pending channel flag evt_overrun.
// Ports: clk/reset, signal_in (async lines), ch_enable, evt_overrun (sticky), overrun_clear, evt (offer handshake).
module edge_event_scheduler
    import edge_evt_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_ANY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      signal_in,
    input  logic [N_CH-1:0]      ch_enable,
    output logic [N_CH-1:0]      evt_overrun,
    input  logic                 overrun_clear,
    edge_event_scheduler_if.master evt
);

    localparam int CH_W     = $clog2(N_CH);
    localparam int ARM_DONE = SYNC_STAGES + 1;
    localparam int ARM_W    = $clog2(SYNC_STAGES + 2);

    logic [ARM_W-1:0] arm_cnt;
    logic             arm;

    logic [N_CH-1:0]  edge_raw;
    logic [N_CH-1:0]  level_s;
    logic [N_CH-1:0]  edge_q;

    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  lvl_q, lvl_d;
    logic [N_CH-1:0]  ovr_q, ovr_set;
    logic [CH_W-1:0]  last_q;
    logic [CH_W-1:0]  chan_q;
    logic             level_q;

    fsm_state_t       state_q, state_d;
    logic             any_pend;
    logic             load;
    logic [CH_W-1:0]  pick_idx;
    logic [N_CH-1:0]  load_onehot;

    // Edges stay masked until prev has caught up with the true line level,
    // so a line sitting high through reset does not look like a rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            arm_cnt <= '0;
        end else if (!arm) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign arm = (arm_cnt == ARM_W'(ARM_DONE));

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        edge_sync_detect #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_det (
            .clk       (clk),
            .reset     (reset),
            .signal_in (signal_in[gi]),
            .arm       (arm),
            .edge_det  (edge_raw[gi]),
            .level     (level_s[gi])
        );
    end

    assign edge_q   = edge_raw & ch_enable;
    assign any_pend = |pending_q;
    assign pick_idx = CH_W'(rr_pick(16'(pending_q), int'(last_q), N_CH));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_pend) state_d = OFFER;
            OFFER:   if (evt.evt_ready && !any_pend) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: load fires on entry from IDLE and on every handshake with work left.
    always_comb begin
        evt.evt_valid = (state_q == OFFER);
        load          = any_pend && ((state_q == IDLE) || evt.evt_ready);
        load_onehot   = load ? (N_CH'(1) << pick_idx) : '0;
    end

    // Pending update. A fresh edge beats the clear from a load on the same channel,
    // and only counts as overrun if the bit was pending and not being drained now.
    always_comb begin
        pending_d = pending_q;
        lvl_d     = lvl_q;
        ovr_set   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!ch_enable[i]) begin
                pending_d[i] = 1'b0;
            end else if (edge_q[i]) begin
                pending_d[i] = 1'b1;
                lvl_d[i]     = level_s[i];
                ovr_set[i]   = pending_q[i] && !load_onehot[i];
            end else if (load_onehot[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
            lvl_q     <= '0;
            ovr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            lvl_q     <= lvl_d;
            ovr_q     <= (overrun_clear ? '0 : ovr_q) | ovr_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chan_q  <= '0;
            level_q <= 1'b0;
            last_q  <= CH_W'(N_CH - 1);
        end else if (load) begin
            chan_q  <= pick_idx;
            level_q <= lvl_q[pick_idx];
            last_q  <= pick_idx;
        end
    end

    assign evt.evt_channel = chan_q;
    assign evt.evt_level   = level_q;
    assign evt_overrun     = ovr_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Scoreboard bench: expected events queued at stimulus time, popped on each handshake.
// Latency: n/a.
// Backpressure: exercised via evt_ready on both instances.
module tb_edge_event_scheduler;
    import edge_evt_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic       lvl;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sig_a, en_a, ovr_a;
    logic       clr_a;
    logic [3:0] sig_b, en_b, ovr_b;
    logic       clr_b;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   ord[4];

    always #5 clk = ~clk;

    edge_event_scheduler_if #(.N_CH(4)) ifa ();
    edge_event_scheduler_if #(.N_CH(4)) ifb ();

    edge_event_scheduler #(.N_CH(4), .SYNC_STAGES(2), .EDGE_MODE(EDGE_ANY)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .signal_in     (sig_a),
        .ch_enable     (en_a),
        .evt_overrun   (ovr_a),
        .overrun_clear (clr_a),
        .evt           (ifa)
    );

    edge_event_scheduler #(.N_CH(4), .SYNC_STAGES(2), .EDGE_MODE(EDGE_FALL)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .signal_in     (sig_b),
        .ch_enable     (en_b),
        .evt_overrun   (ovr_b),
        .overrun_clear (clr_b),
        .evt           (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input int ch, input logic lvl);
        qa.push_back('{ch: 2'(ch), lvl: lvl});
    endtask

    task automatic push_b(input int ch, input logic lvl);
        qb.push_back('{ch: 2'(ch), lvl: lvl});
    endtask

    task automatic drain_a();
        for (int i = 0; i < 30 && qa.size() != 0; i++) tick();
        check("drain_a", 32'(qa.size()), 0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 30 && qb.size() != 0; i++) tick();
        check("drain_b", 32'(qb.size()), 0);
    endtask

    task automatic wait_valid_a();
        for (int i = 0; i < 12 && !ifa.evt_valid; i++) tick();
        check("wait_valid_a", 32'(ifa.evt_valid), 1);
    endtask

    // Handshake monitors: every accepted event must match the head of its queue.
    always @(negedge clk) begin
        if (reset && ifa.evt_valid && ifa.evt_ready) begin
            check("evt_expected_a", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check("evt_chan_a", 32'(ifa.evt_channel), 32'(ea.ch));
                check("evt_lvl_a", 32'(ifa.evt_level), 32'(ea.lvl));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && ifb.evt_valid && ifb.evt_ready) begin
            check("evt_expected_b", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check("evt_chan_b", 32'(ifb.evt_channel), 32'(eb.ch));
                check("evt_lvl_b", 32'(ifb.evt_level), 32'(eb.lvl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        sig_a = 4'b0101; en_a = 4'b1111; clr_a = 1'b0; ifa.evt_ready = 1'b1;
        sig_b = 4'b0000; en_b = 4'b1111; clr_b = 1'b0; ifb.evt_ready = 1'b1;

        // Reset values and priming with lines high through reset
        tick(3);
        check("rst_valid", 32'(ifa.evt_valid), 0);
        check("rst_chan", 32'(ifa.evt_channel), 0);
        check("rst_level", 32'(ifa.evt_level), 0);
        check("rst_ovr", 32'(ovr_a), 0);
        reset = 1'b1;
        tick(10);
        check("prime_valid", 32'(ifa.evt_valid), 0);
        check("prime_ovr", 32'(ovr_a), 0);

        // Bring ch0/ch2 low so ch2 can rise from a quiet scheduler
        sig_a = 4'b0000;
        push_a(0, 1'b0);
        push_a(2, 1'b0);
        drain_a();
        tick(2);

        // Single edge latency: valid appears after edge k+3 for one cycle
        sig_a = 4'b0100;
        push_a(2, 1'b1);
        tick();
        check("lat_k0", 32'(ifa.evt_valid), 0);
        tick();
        check("lat_k1", 32'(ifa.evt_valid), 0);
        tick();
        check("lat_k2", 32'(ifa.evt_valid), 0);
        tick();
        check("lat_k3_valid", 32'(ifa.evt_valid), 1);
        check("lat_k3_chan", 32'(ifa.evt_channel), 2);
        check("lat_k3_lvl", 32'(ifa.evt_level), 1);
        tick();
        check("lat_k4_valid", 32'(ifa.evt_valid), 0);
        drain_a();

        // Return ch2 low, then reset so the round-robin pointer starts at ch0
        sig_a = 4'b0000;
        push_a(2, 1'b0);
        drain_a();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(5);

        // Burst 1: all four rise together
        sig_a = 4'b1111;
        for (int i = 0; i < 4; i++) push_a(i, 1'b1);
        ord = '{0, 1, 2, 3};
        wait_valid_a();
        for (int i = 0; i < 4; i++) begin
            check("rr1_valid", 32'(ifa.evt_valid), 1);
            check("rr1_chan", 32'(ifa.evt_channel), 32'(ord[i]));
            tick();
        end
        check("rr1_end", 32'(ifa.evt_valid), 0);
        drain_a();

        // Leave the last grant on ch1
        sig_a = 4'b1100;
        push_a(0, 1'b0);
        push_a(1, 1'b0);
        drain_a();
        tick(2);

        // Burst 2: four simultaneous edges, search starts after ch1
        sig_a = 4'b0011;
        push_a(2, 1'b0);
        push_a(3, 1'b0);
        push_a(0, 1'b1);
        push_a(1, 1'b1);
        ord = '{2, 3, 0, 1};
        wait_valid_a();
        for (int i = 0; i < 4; i++) begin
            check("rr2_valid", 32'(ifa.evt_valid), 1);
            check("rr2_chan", 32'(ifa.evt_channel), 32'(ord[i]));
            tick();
        end
        drain_a();
        tick(2);

        // Backpressure: ch0 holds the offer while ch1 toggles twice
        ifa.evt_ready = 1'b0;
        sig_a = 4'b0010;
        push_a(0, 1'b0);
        tick(4);
        sig_a = 4'b0000;
        tick(4);
        sig_a = 4'b0010;
        tick(4);
        check("bp_ovr", 32'(ovr_a), 32'h2);
        check("bp_valid", 32'(ifa.evt_valid), 1);
        check("bp_chan", 32'(ifa.evt_channel), 0);

        // Clear racing a fresh ch1 overrun: the new overrun survives
        sig_a = 4'b0000;
        tick(2);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("ovr_clr_race", 32'(ovr_a), 32'h2);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("ovr_clr", 32'(ovr_a), 0);
        push_a(1, 1'b0);
        ifa.evt_ready = 1'b1;
        drain_a();
        tick();
        check("bp_end_valid", 32'(ifa.evt_valid), 0);

        // Reset while offering with two more pending
        ifa.evt_ready = 1'b0;
        sig_a = 4'b1110;
        tick(5);
        check("mid_valid", 32'(ifa.evt_valid), 1);
        reset = 1'b0;
        tick();
        check("mid_rst_valid", 32'(ifa.evt_valid), 0);
        check("mid_rst_ovr", 32'(ovr_a), 0);
        tick();
        reset = 1'b1;
        ifa.evt_ready = 1'b1;
        tick(15);
        check("mid_post_valid", 32'(ifa.evt_valid), 0);

        // EDGE_FALL instance: rise ignored, fall reported with level 0
        sig_b = 4'b0001;
        tick(6);
        check("fall_no_rise", 32'(ifb.evt_valid), 0);
        sig_b = 4'b0000;
        push_b(0, 1'b0);
        drain_b();

        // Disabled channel produces nothing
        en_b[3] = 1'b0;
        sig_b[3] = 1'b1;
        tick(4);
        sig_b[3] = 1'b0;
        tick(6);
        check("dis_no_evt", 32'(ifb.evt_valid), 0);
        en_b[3] = 1'b1;
        tick(2);

        // Disabling a pending channel drops it
        ifb.evt_ready = 1'b0;
        sig_b[0] = 1'b1;
        tick(4);
        sig_b[0] = 1'b0;
        push_b(0, 1'b0);
        tick(5);
        sig_b[3] = 1'b1;
        tick(4);
        sig_b[3] = 1'b0;
        tick(4);
        check("drop_offer_valid", 32'(ifb.evt_valid), 1);
        check("drop_offer_chan", 32'(ifb.evt_channel), 0);
        en_b[3] = 1'b0;
        tick();
        en_b[3] = 1'b1;
        ifb.evt_ready = 1'b1;
        tick(8);
        check("dis_drop", 32'(ifb.evt_valid), 0);

        check("qa_empty", 32'(qa.size()), 0);
        check("qb_empty", 32'(qb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_scheduler.md
# edge_event_scheduler

Collects edge events from `N_CH` asynchronous input lines and delivers them one at a time to a single downstream consumer over a valid/ready handshake. Each channel is synchronized and edge-detected, then latched into a pending bit. A round-robin scheduler then serializes the pending events onto one shared event port. It sits between raw board-level strobes (buttons, bus control lines) and the control logic that services them, and it flags any event lost to overrun.

## Interface
- `N_CH`, default 4: number of input channels, range 2..16.
- `SYNC_STAGES`, default 2: synchronizer depth, minimum 2.
- `EDGE_MODE`, default `EDGE_ANY`: which edges count. One of `EDGE_ANY`, `EDGE_RISE` or `EDGE_FALL`; applies to all channels.

- `clk`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-low reset.
- `signal_in`, in, `N_CH`: asynchronous input lines.
- `ch_enable`, in, `N_CH`: per-channel enable, synchronous to `clk`.
- `evt_valid`, out, 1: an event is offered.
- `evt_ready`, in, 1: the consumer accepts the offered event.
- `evt_channel`, out, `$clog2(N_CH)`: index of the offered channel.
- `evt_level`, out, 1: synchronized level of the channel just after its edge (1 = rising, 0 = falling).
- `evt_overrun`, out, `N_CH`: sticky per-channel flag, set when an event is lost.
- `overrun_clear`, in, 1: clears all `evt_overrun` bits.

## Operation
- **Per-channel path.** `signal_in` → `SYNC_STAGES` flops → `prev` register. An edge is detected when `sync_out != prev`, then qualified by `EDGE_MODE` and `ch_enable`.
- **Edge arming.** Edges are suppressed for `SYNC_STAGES+1` cycles after reset deasserts. This lets `prev` prime to the true input level, so a line that is high at reset produces no event.
- **Pending capture.** A qualified edge sets `pending[i]` and stores `lvl[i] = sync_out`.
- **Overrun.** If an edge arrives while `pending[i]` is already set and channel i is not being loaded into the offer that same cycle, `evt_overrun[i]` is set. `lvl[i]` takes the newer level.
- **Edge during load.** If an edge arrives on the channel being loaded that cycle, `pending[i]` stays set (set wins). This is not an overrun.
- **Channel disable.** Deasserting `ch_enable[i]` clears `pending[i]`. An offer already presented on channel i is not withdrawn.
- **FSM, `IDLE`:**
  - If any bit is pending, pick the first pending channel searching from `last+1` modulo `N_CH`.
  - Register `evt_channel` and `evt_level`, clear that pending bit, update `last`, and go to `OFFER`.
- **FSM, `OFFER`:**
  - `evt_valid` = 1. `evt_channel` and `evt_level` are held stable until `evt_valid && evt_ready`.
  - On handshake with another bit pending: load the next winner in the same cycle and stay in `OFFER` (back-to-back).
  - On handshake with nothing pending: go to `IDLE`.
- **Overrun clear.** `overrun_clear` clears all overrun bits. A new overrun arriving in the same cycle wins for its channel.

## Timing
- **Reset values:** `evt_valid` = 0, `evt_channel` = 0, `evt_level` = 0, `evt_overrun` = 0. Sync flops, `prev`, pending bits and `lvl` reset to 0. `last` resets to `N_CH-1`, so channel 0 wins first. FSM resets to `IDLE`.
- **Latency:** with the input stable before edge k and the scheduler idle, `pending` is set at edge k+`SYNC_STAGES` and `evt_valid` rises after edge k+`SYNC_STAGES`+1. For `SYNC_STAGES` = 2 that is 3 cycles.
- **Throughput:** one event per cycle while `evt_ready` is held high and events are pending.
- **`evt_ready` while idle:** ignored when `evt_valid` = 0.
- **Reset mid-operation:**
  - The offer, pending bits and overrun flags are dropped.
  - Edges are re-armed per the edge-arming rule.
  - No event is emitted for input levels present during reset.
- **Width rules:** `evt_channel` uses modulo-`N_CH` wrap in the round-robin search. For non-power-of-two `N_CH`, indices ≥ `N_CH` are never produced.

## Structure
- **Package `edge_evt_pkg`:**
  - Constants `EDGE_ANY` = 0, `EDGE_RISE` = 1, `EDGE_FALL` = 2.
  - FSM state type {`IDLE`, `OFFER`}.
  - Round-robin pick function (pending vector, last index → next index).
- **Sub-module `edge_sync_detect`:**
  - Generated once per channel.
  - Contains the sync chain, `prev`, and the mode-qualified edge output.
  - Takes an arm input used for post-reset suppression.
- **Top level:** holds the pending/overrun/`lvl` registers, the arming counter, and the FSM.

## Test plan
- **Reset priming:** `signal_in` = 4'b0101 held through reset; release reset; 10 cycles → `evt_valid` stays 0 and `evt_overrun` = 0.
- **Single edge:** ch2 rises at edge k with `evt_ready` = 1 → after edge k+3, `evt_valid` = 1, `evt_channel` = 2, `evt_level` = 1, for exactly one cycle.
- **Round-robin:** simultaneous rising edges on ch0..3 with `evt_ready` = 1 → events come out in order 0, 1, 2, 3 on consecutive cycles. A second burst after the last grant went to ch1 comes out in order 2, 3, 0, 1.
- **Backpressure and overrun:**
  - Setup: `evt_ready` = 0; ch1 toggles twice, 4 cycles apart.
  - Expect: ch1 is offered once and `evt_overrun[1]` = 1.
  - Then `overrun_clear` plus a new ch1 overrun in the same cycle → `evt_overrun[1]` remains 1.
- **`EDGE_FALL`, disable:** with `EDGE_FALL`, a ch0 rise produces no event and a ch0 fall gives `evt_level` = 0. A ch3 edge with `ch_enable[3]` = 0 produces no event; clearing `ch_enable[3]` while ch3 is pending drops it.
- **Reset mid-offer:** `reset` = 0 while `evt_valid` = 1 and 2 bits are pending → next cycle `evt_valid` = 0, and no events are emitted after release.
